top: RTL and testbench

TOP -- requirements
Module: Top

---
 rtl/top.sv | 226 ++++++++++++++++++++++
 tb/tb_top.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// ---------------------------------------------------------------------------------------------
// top: IEEE 1149.1 TAP controller with a 2-bit instruction register and three data registers:
// BYPASS, IDCODE (optional), and a USER register with a parallel capture/update path.
//
// Optional feature macro: TOP_IDCODE_EN
//   defined   -> 32-bit IDCODE register present; instruction 2'b01 selects it and it is the
//                reset instruction.
//   undefined -> no IDCODE register; 2'b01 decodes as BYPASS and BYPASS is the reset
//                instruction.
//
// Parameters:
//   IDCODE_VALUE  device identification code, LSB must be 1
//   USER_WIDTH    width of the USER data register (>= 2)
//
// Ports:
//   TCK       test clock; the only clock, all state is clocked by it
//   TRST      asynchronous active-low test reset
//   TMS       test mode select, sampled on TCK rising edge
//   TDI       serial data in, sampled on TCK rising edge
//   TDO       serial data out, registered on TCK falling edge
//   user_in   parallel value captured into the USER register in Capture-DR
//   user_out  parallel value loaded from the USER register in Update-DR
// ---------------------------------------------------------------------------------------------
module top #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_5A5F,
  parameter int unsigned USER_WIDTH   = 8
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic [USER_WIDTH-1:0] user_out
);

  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE_VALUE LSB must be 1");
  end

  typedef enum logic [3:0] {
    StTlr,
    StRti,
    StSelDr,
    StCapDr,
    StShiftDr,
    StExit1Dr,
    StPauseDr,
    StExit2Dr,
    StUpdDr,
    StSelIr,
    StCapIr,
    StShiftIr,
    StExit1Ir,
    StPauseIr,
    StExit2Ir,
    StUpdIr
  } state_e;

  typedef enum logic [1:0] {
    InsBypass,
    InsIdcode,
    InsUser
  } instr_e;

`ifdef TOP_IDCODE_EN
  localparam instr_e ResetInstr = InsIdcode;
`else
  localparam instr_e ResetInstr = InsBypass;
`endif

  // Standard 1149.1 TMS transition table.
  function automatic state_e next_state(input state_e st, input logic tms);
    state_e ns;
    case (st)
      StTlr:     ns = tms ? StTlr     : StRti;
      StRti:     ns = tms ? StSelDr   : StRti;
      StSelDr:   ns = tms ? StSelIr   : StCapDr;
      StCapDr:   ns = tms ? StExit1Dr : StShiftDr;
      StShiftDr: ns = tms ? StExit1Dr : StShiftDr;
      StExit1Dr: ns = tms ? StUpdDr   : StPauseDr;
      StPauseDr: ns = tms ? StExit2Dr : StPauseDr;
      StExit2Dr: ns = tms ? StUpdDr   : StShiftDr;
      StUpdDr:   ns = tms ? StSelDr   : StRti;
      StSelIr:   ns = tms ? StTlr     : StCapIr;
      StCapIr:   ns = tms ? StExit1Ir : StShiftIr;
      StShiftIr: ns = tms ? StExit1Ir : StShiftIr;
      StExit1Ir: ns = tms ? StUpdIr   : StPauseIr;
      StPauseIr: ns = tms ? StExit2Ir : StPauseIr;
      StExit2Ir: ns = tms ? StUpdIr   : StShiftIr;
      StUpdIr:   ns = tms ? StSelDr   : StRti;
      default:   ns = StTlr;
    endcase
    return ns;
  endfunction

  function automatic instr_e decode(input logic [1:0] code);
    instr_e ins;
    case (code)
      2'b10:   ins = InsUser;
`ifdef TOP_IDCODE_EN
      2'b01:   ins = InsIdcode;
`endif
      default: ins = InsBypass;
    endcase
    return ins;
  endfunction

  state_e                  state_q;
  instr_e                  ir_q;
  logic [1:0]              ir_sr_q;
  logic                    bypass_q;
  logic [USER_WIDTH-1:0]   user_sr_q;
  logic [USER_WIDTH-1:0]   user_out_q;
  logic                    tdo_d;
  logic                    tdo_q;
  logic                    enter_tlr;

  // Reset values are applied on the edge that enters Test-Logic-Reset, so the instruction and
  // user_out are already restored while the FSM sits in that state.
  assign enter_tlr = (next_state(state_q, TMS) == StTlr);

  // TAP state machine.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= StTlr;
    end else begin
      state_q <= next_state(state_q, TMS);
    end
  end

  // Instruction shift register and active instruction.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q <= 2'b01;
      ir_q    <= ResetInstr;
    end else if (enter_tlr) begin
      ir_sr_q <= 2'b01;
      ir_q    <= ResetInstr;
    end else begin
      case (state_q)
        StCapIr:   ir_sr_q <= 2'b01;
        StShiftIr: ir_sr_q <= {TDI, ir_sr_q[1]};
        StUpdIr:   ir_q    <= decode(ir_sr_q);
        default:   ;
      endcase
    end
  end

  // BYPASS register: only active while BYPASS is the selected instruction.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_q <= 1'b0;
    end else if (ir_q == InsBypass) begin
      if (state_q == StCapDr) begin
        bypass_q <= 1'b0;
      end else if (state_q == StShiftDr) begin
        bypass_q <= TDI;
      end
    end
  end

`ifdef TOP_IDCODE_EN
  logic [31:0] idcode_sr_q;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      idcode_sr_q <= IDCODE_VALUE;
    end else if (ir_q == InsIdcode) begin
      if (state_q == StCapDr) begin
        idcode_sr_q <= IDCODE_VALUE;
      end else if (state_q == StShiftDr) begin
        idcode_sr_q <= {TDI, idcode_sr_q[31:1]};
      end
    end
  end
`endif

  // USER shift register and its parallel output latch.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      user_sr_q  <= '0;
      user_out_q <= '0;
    end else if (enter_tlr) begin
      user_out_q <= '0;
    end else if (ir_q == InsUser) begin
      case (state_q)
        StCapDr:   user_sr_q  <= user_in;
        StShiftDr: user_sr_q  <= {TDI, user_sr_q[USER_WIDTH-1:1]};
        StUpdDr:   user_out_q <= user_sr_q;
        default:   ;
      endcase
    end
  end

  assign user_out = user_out_q;

  // TDO source: IR LSB in Shift-IR, selected DR LSB in Shift-DR, otherwise quiet.
  always_comb begin
    tdo_d = 1'b0;
    case (state_q)
      StShiftIr: tdo_d = ir_sr_q[0];
      StShiftDr: begin
        case (ir_q)
          InsUser:   tdo_d = user_sr_q[0];
`ifdef TOP_IDCODE_EN
          InsIdcode: tdo_d = idcode_sr_q[0];
`endif
          default:   tdo_d = bypass_q;
        endcase
      end
      default:   tdo_d = 1'b0;
    endcase
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= tdo_d;
    end
  end

  assign TDO = tdo_q;

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------------------------
// tb_top: self-checking bench for the TAP controller in top. TDO bits are sampled just before
// the rising edge that consumes the matching TMS/TDI, as a JTAG host would.
// ---------------------------------------------------------------------------------------------
module tb_top;

  localparam logic [31:0] IdcodeValue = 32'h1000_5A5F;
  localparam int unsigned UserWidth   = 8;

  logic                 TCK;
  logic                 TRST;
  logic                 TMS;
  logic                 TDI;
  logic                 TDO;
  logic [UserWidth-1:0] user_in;
  logic [UserWidth-1:0] user_out;

  int n_vec;
  int n_err;

  logic exp_q[$];

  top #(
    .IDCODE_VALUE(IdcodeValue),
    .USER_WIDTH  (UserWidth)
  ) dut (
    .TCK     (TCK),
    .TRST    (TRST),
    .TMS     (TMS),
    .TDI     (TDI),
    .TDO     (TDO),
    .user_in (user_in),
    .user_out(user_out)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] ir;
    logic [7:0] uin;
    logic [7:0] tdi;
    logic [7:0] exp_tdo;
    logic [7:0] exp_uout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One TCK cycle: drive TMS/TDI, report TDO as seen before the consuming rising edge.
  task automatic tick(input logic tms, input logic tdi, output logic tdo);
    TMS = tms;
    TDI = tdi;
    @(negedge TCK);
    #1 tdo = TDO;
    @(posedge TCK);
    #1;
  endtask

  // Expected 8-bit DR read-out when the reset instruction is active.
  function automatic logic [7:0] reset_instr_dr8(input logic [7:0] tdi);
`ifdef TOP_IDCODE_EN
    return IdcodeValue[7:0];
`else
    return {tdi[6:0], 1'b0};
`endif
  endfunction

  // From Run-Test/Idle: load a 2-bit instruction, back to Run-Test/Idle.
  task automatic load_ir(input logic [1:0] code);
    logic t;
    logic e;
    tick(1'b1, 1'b0, t);
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b0, t);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      tick((i == 1), code[i], t);
      e = exp_q.pop_front();
      check($sformatf("ir_capture_bit%0d", i), {31'b0, t}, {31'b0, e});
    end
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
  endtask

  // From Run-Test/Idle: shift n DR bits (optionally detouring through Pause-DR after bit
  // pause_at-1), then Update-DR and back to Run-Test/Idle.
  task automatic shift_dr(input int n, input logic [31:0] tdi, input logic [31:0] exp,
                          input int pause_at, input string name);
    logic t;
    logic e;
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
    for (int i = 0; i < n; i++) begin
      tick((i == n - 1) || (i == pause_at - 1), tdi[i], t);
      e = exp_q.pop_front();
      check($sformatf("%s_bit%0d", name, i), {31'b0, t}, {31'b0, e});
      if (pause_at > 0 && i == pause_at - 1 && i != n - 1) begin
        tick(1'b0, 1'b1, t);
        tick(1'b0, 1'b1, t);
        tick(1'b1, 1'b1, t);
        tick(1'b0, 1'b1, t);
      end
    end
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
  endtask

  vec_t vecs[6];

  initial begin
    logic        t;
    logic [31:0] rnd;
    logic [31:0] exp32;

    vecs[0] = '{ir: 2'b10, uin: 8'hC3, tdi: 8'h5A, exp_tdo: 8'hC3, exp_uout: 8'h5A};
    vecs[1] = '{ir: 2'b11, uin: 8'h3C, tdi: 8'hA7, exp_tdo: 8'h4E, exp_uout: 8'h5A};
    vecs[2] = '{ir: 2'b10, uin: 8'h96, tdi: 8'h81, exp_tdo: 8'h96, exp_uout: 8'h81};
    vecs[3] = '{ir: 2'b00, uin: 8'hFF, tdi: 8'h33, exp_tdo: 8'h66, exp_uout: 8'h81};
`ifdef TOP_IDCODE_EN
    vecs[4] = '{ir: 2'b01, uin: 8'h12, tdi: 8'hF0, exp_tdo: 8'h5F, exp_uout: 8'h81};
`else
    vecs[4] = '{ir: 2'b01, uin: 8'h12, tdi: 8'hF0, exp_tdo: 8'hE0, exp_uout: 8'h81};
`endif
    vecs[5] = '{ir: 2'b10, uin: 8'h0F, tdi: 8'h00, exp_tdo: 8'h0F, exp_uout: 8'h00};

    n_vec   = 0;
    n_err   = 0;
    TRST    = 1'b0;
    TMS     = 1'b1;
    TDI     = 1'b0;
    user_in = '0;

    // Reset pulse, then one TMS=0 edge into Run-Test/Idle.
    @(posedge TCK);
    @(posedge TCK);
    #1;
    check("reset_tdo", {31'b0, TDO}, 32'd0);
    check("reset_user_out", {24'b0, user_out}, 32'd0);
    TRST = 1'b1;
    tick(1'b0, 1'b0, t);
    check("tlr_tdo", {31'b0, t}, 32'd0);
    tick(1'b0, 1'b0, t);
    check("rti_tdo", {31'b0, t}, 32'd0);
    check("rti_user_out", {24'b0, user_out}, 32'd0);

    // Straight to Shift-DR under the reset instruction, 32 bits.
    rnd = $urandom;
`ifdef TOP_IDCODE_EN
    exp32 = IdcodeValue;
`else
    exp32 = {rnd[30:0], 1'b0};
`endif
    shift_dr(32, rnd, exp32, 0, "reset_dr32");

    // BYPASS: captured 0 then TDI delayed one TCK.
    load_ir(2'b11);
    shift_dr(5, 32'b11001, 32'b10010, 0, "bypass5");

    // Table of instruction / data vectors.
    foreach (vecs[k]) begin
      user_in = vecs[k].uin;
      load_ir(vecs[k].ir);
      shift_dr(8, {24'b0, vecs[k].tdi}, {24'b0, vecs[k].exp_tdo}, 0, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_user_out", k), {24'b0, user_out}, {24'b0, vecs[k].exp_uout});
    end

    // Pause-DR in the middle of a USER shift must not disturb the stream.
    user_in = 8'hA5;
    load_ir(2'b10);
    shift_dr(8, 32'h3C, 32'hA5, 4, "pause");
    check("pause_user_out", {24'b0, user_out}, 32'h3C);

    // Five TMS=1 from Shift-DR reaches Test-Logic-Reset and restores reset values.
    user_in = 8'h11;
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    tick(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, t);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t);
    check("tms_reset_user_out", {24'b0, user_out}, 32'd0);
    tick(1'b0, 1'b0, t);
    user_in = 8'hAA;
    shift_dr(8, 32'hC5, {24'b0, reset_instr_dr8(8'hC5)}, 0, "tms_reset_dr");
    check("tms_reset_user_out2", {24'b0, user_out}, 32'd0);

    // TRST asserted in the middle of a USER Shift-DR.
    user_in = 8'hFF;
    load_ir(2'b10);
    shift_dr(8, 32'h77, 32'hFF, 0, "pre_trst");
    check("pre_trst_user_out", {24'b0, user_out}, 32'h77);
    tick(1'b1, 1'b0, t);
    tick(1'b0, 1'b0, t);
    TMS = 1'b0;
    @(posedge TCK);
    @(negedge TCK);
    #1;
    check("mid_shift_tdo", {31'b0, TDO}, 32'd1);
    TRST = 1'b0;
    #1;
    check("trst_tdo", {31'b0, TDO}, 32'd0);
    check("trst_user_out", {24'b0, user_out}, 32'd0);
    @(posedge TCK);
    #1;
    TRST = 1'b1;
    tick(1'b1, 1'b0, t);
    check("post_trst_tdo0", {31'b0, t}, 32'd0);
    tick(1'b1, 1'b1, t);
    check("post_trst_tdo1", {31'b0, t}, 32'd0);
    tick(1'b0, 1'b1, t);
    user_in = 8'h3C;
    shift_dr(8, 32'h96, {24'b0, reset_instr_dr8(8'h96)}, 0, "post_trst_dr");
    check("post_trst_user_out", {24'b0, user_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
